// File: rtl/res_out_serializer.sv
// Drains result words from the output FIFO and serializes them LSB-first as
// OUT_WIDTH-bit beats over valid/ready, flagging the final beat of each result.
module res_out_serializer #(
    parameter int DATA_WIDTH       = 32,
    parameter int OUT_WIDTH        = 8,
    parameter int WORDS_PER_RESULT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           res_count
);

    localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (WORDS_PER_RESULT > 1) ? $clog2(WORDS_PER_RESULT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_RESULT - 1);

    typedef enum logic [1:0] {IDLE, REQ, CAPT, SEND} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_beat_cnt;
    logic [WW-1:0]         r_word_cnt;
    logic [15:0]           r_res_count;
    logic                  w_fire;
    logic                  w_last_beat;
    logic                  w_last_word;

    assign w_fire      = (r_state == SEND) && out_ready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_last_word = (r_word_cnt == LAST_WORD);
    assign res_count   = r_res_count;

    always_comb begin
        w_next     = r_state;
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            IDLE: if (!fifo_empty) w_next = REQ;
            REQ: begin
                fifo_rd_en = 1'b1;
                w_next     = CAPT;
            end
            CAPT: w_next = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_data  = r_shift[OUT_WIDTH-1:0];
                out_last  = w_last_word && w_last_beat;
                // word_cnt survives IDLE so a result may straddle a FIFO underrun
                if (w_fire && w_last_beat) begin
                    if (w_last_word || fifo_empty) w_next = IDLE;
                    else                           w_next = REQ;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_beat_cnt  <= '0;
            r_word_cnt  <= '0;
            r_res_count <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                CAPT: begin
                    r_shift    <= fifo_dout;
                    r_beat_cnt <= '0;
                end
                SEND: begin
                    if (w_fire) begin
                        r_shift    <= r_shift >> OUT_WIDTH;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) begin
                            if (w_last_word) begin
                                r_word_cnt  <= '0;
                                r_res_count <= r_res_count + 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_res_out_serializer.sv
// Scoreboard bench for res_out_serializer: a queue-based FIFO model feeds the
// DUT, expected beats are queued at push time and popped by a monitor.
module tb_res_out_serializer;

    localparam int DW    = 32;
    localparam int OW    = 8;
    localparam int WPR   = 64;
    localparam int BEATS = DW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic [15:0]   res_count;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [DW-1:0] fifo_q[$];
    logic [OW:0]   exp_q[$];     // {last, byte}
    int unsigned   model_widx = 0;
    logic [15:0]   exp_res = '0;
    int unsigned   rd_pulses = 0;
    int unsigned   ready_mode = 0;
    int unsigned   cyc = 0;
    logic          fifo_clr = 1'b0;
    logic          rd_seen = 1'b0;
    logic          prev_rst = 1'b0;
    logic          stalled = 1'b0;
    logic          after_last = 1'b0;
    logic [OW-1:0] held_data = '0;
    logic          held_last = 1'b0;
    logic [OW:0]   e;

    res_out_serializer #(
        .DATA_WIDTH(DW),
        .OUT_WIDTH(OW),
        .WORDS_PER_RESULT(WPR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .res_count(res_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: each word yields BEATS bytes LSB first; last flag on the
    // final byte of every WPR-th word.
    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back({(model_widx == WPR - 1) && (b == BEATS - 1), w[b*OW +: OW]});
        model_widx = (model_widx + 1) % WPR;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // FIFO model with registered empty flag and one-cycle read latency
    always @(posedge clk) begin
        cyc++;
        if (rd_seen) begin
            rd_pulses++;
            chk("rd_nonempty", 64'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
            else                    fifo_dout <= '0;
        end else begin
            fifo_dout <= '0;
        end
        if (rst && fifo_clr) fifo_q.delete();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
    end

    always @(negedge clk) begin
        rd_seen = fifo_rd_en;
        if (rst) begin
            if (prev_rst)
                chk("reset_outputs", 64'({fifo_rd_en, out_valid, out_last, busy, out_data, res_count}), 0);
            stalled    = 1'b0;
            after_last = 1'b0;
        end else begin
            chk("res_count", 64'(res_count), 64'(exp_res));
            if (after_last) chk("busy_drop", 64'(busy), 0);
            after_last = 1'b0;
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 1);
                chk("stall_data", 64'(out_data), 64'(held_data));
                chk("stall_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat got=%0h exp=none t=%0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(out_data), 64'(e[OW-1:0]));
                    chk("beat_last", 64'(out_last), 64'(e[OW]));
                    if (e[OW]) begin
                        exp_res++;
                        after_last = 1'b1;
                    end
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
        end
        prev_rst = rst;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        // Reset with FIFO non-empty, then read latency
        ready_mode = 0;
        @(posedge clk); #1;
        push_word(32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk); chk("lat_rd_t", 64'(fifo_rd_en), 0);
        @(negedge clk); chk("lat_rd_t1", 64'(fifo_rd_en), 1);
        @(negedge clk); chk("lat_valid_t2", 64'(out_valid), 0);
        @(negedge clk); chk("lat_valid_t3", 64'(out_valid), 1);

        // Full result, words = index
        @(posedge clk); #1;
        ready_mode = 1;
        for (int i = 1; i < WPR; i++) push_word(DW'(i));
        wait_drain(5000);
        chk("rd_pulses", 64'(rd_pulses), 64);
        chk("res_after_full", 64'(res_count), 1);

        // Known final word with ready held high
        ready_mode = 0;
        for (int i = 0; i < WPR - 1; i++) push_word($urandom);
        push_word(32'hA1B2C3D4);
        wait_drain(3000);
        chk("res_after_known", 64'(res_count), 2);

        // Backpressure pattern 1,0,0,1
        ready_mode = 2;
        for (int i = 0; i < WPR; i++) push_word($urandom);
        wait_drain(5000);
        chk("res_after_bp", 64'(res_count), 3);

        // Underrun after word 10
        ready_mode = 1;
        for (int i = 0; i < 11; i++) push_word($urandom);
        wait_drain(2000);
        repeat (20) @(posedge clk);
        #1;
        chk("underrun_idle", 64'(busy), 0);
        chk("underrun_word_cnt", 64'(dut.r_word_cnt), 11);
        for (int i = 11; i < WPR; i++) push_word($urandom);
        wait_drain(5000);
        chk("res_after_underrun", 64'(res_count), 4);

        // Reset mid-result after 5 words, then a clean result
        for (int i = 0; i < WPR; i++) push_word($urandom);
        n = 0;
        while (exp_q.size() > (WPR - 5) * BEATS && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("mid_reset_reach", 64'(exp_q.size() <= (WPR - 5) * BEATS), 1);
        #1;
        rst = 1'b1;
        fifo_clr = 1'b1;
        exp_q.delete();
        model_widx = 0;
        exp_res = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_clr = 1'b0;
        for (int i = 0; i < WPR; i++) push_word($urandom);
        wait_drain(5000);
        chk("res_after_mid_reset", 64'(res_count), 1);

        // Random results with random push gaps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < WPR; i++) begin
                push_word($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 30)) @(posedge clk);
                    #1;
                end
            end
            wait_drain(6000);
            chk("res_after_random", 64'(res_count), 64'(2 + r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/res_out_serializer.md
# res_out_serializer

Drains modular-exponentiation results from the result output FIFO and serializes them as a byte stream toward the off-chip link. Each result is WORDS_PER_RESULT FIFO words. Every word is split into DATA_WIDTH/OUT_WIDTH bytes and sent least-significant byte first over a valid/ready handshake. The final byte of each result is flagged. The block sits directly downstream of the result FIFO and is its only reader.

## Interface
Parameters:
- DATA_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH
- OUT_WIDTH, 8, output beat width
- WORDS_PER_RESULT, 64, FIFO words per result (2048-bit result at defaults)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read request
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid only in the cycle after an accepted read, zero otherwise
- out_data  out  OUT_WIDTH  serialized byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts beat when out_valid && out_ready
- out_last  out  1  high with the final beat of a result
- busy  out  1  high in any state other than IDLE
- res_count  out  16  number of results fully transmitted, wraps at 2^16

## Operation
- FSM states: IDLE, REQ, CAPT, SEND.
- IDLE: if !fifo_empty, go to REQ; otherwise stay.
- REQ: drive fifo_rd_en=1 for exactly one cycle, then go to CAPT.
- REQ is entered only when fifo_empty=0 was sampled, so the read is always accepted.
- CAPT: load fifo_dout into the shift register, clear beat_cnt, go to SEND.
- SEND: out_valid=1 and out_data=shift[OUT_WIDTH-1:0].
- On each handshake in SEND: shift right by OUT_WIDTH and increment beat_cnt.
- On the handshake of the last beat of a word:
  - if word_cnt==WORDS_PER_RESULT-1: clear word_cnt, increment res_count, go to IDLE;
  - else increment word_cnt; go to REQ if !fifo_empty, otherwise go to IDLE.
- word_cnt persists across IDLE, so a result can be sent across FIFO underruns.
- out_last = (state==SEND) && (word_cnt==WORDS_PER_RESULT-1) && (beat_cnt==DATA_WIDTH/OUT_WIDTH-1).
- Counter widths:
  - word_cnt is $clog2(WORDS_PER_RESULT) bits.
  - beat_cnt is $clog2(DATA_WIDTH/OUT_WIDTH) bits, minimum 1.
- res_count wraps 0xFFFF -> 0x0000 with no flag.
- fifo_rd_en is never asserted outside REQ. The block never reads a FIFO it saw as empty.

## Timing
- Reset values: state=IDLE, fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, busy=0, res_count=0, word_cnt=0, beat_cnt=0, shift register=0.
- Reset mid-operation:
  - The in-flight partial result is discarded and all counters clear.
  - Any FIFO word already read is lost; the FIFO owner resets the FIFO together with this block.
- Read latency:
  - IDLE sees !fifo_empty in cycle t.
  - fifo_rd_en=1 in cycle t+1.
  - fifo_dout is captured at the end of cycle t+2.
  - First out_valid is in cycle t+3.
- Steady state with out_ready held high:
  - 4 beats per word, plus 2 overhead cycles (REQ, CAPT).
  - 6 cycles per 32-bit word at defaults.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_last and the state hold stable.
  - out_valid never drops without a handshake, except on rst.
- out_ready is ignored outside SEND.
- fifo_empty is sampled only in IDLE and on the last-beat handshake.

## Test plan
- Reset: assert rst for 2 cycles with the FIFO non-empty -> all outputs 0, no fifo_rd_en during reset, first fifo_rd_en exactly 1 cycle after rst deasserts.
- Single word, WORDS_PER_RESULT=1, fifo_dout=0xA1B2C3D4, out_ready=1:
  - bytes D4, C3, B2, A1 on consecutive cycles;
  - out_last only with A1;
  - res_count 0 -> 1;
  - busy drops the cycle after A1.
- Backpressure: toggle out_ready 1,0,0,1 during a word -> no beat lost or duplicated; out_data stable during the stalled cycles.
- Full 64-word result, words 0..63 = word index:
  - 256 beats, out_last only on beat 255;
  - fifo_rd_en pulses exactly 64 times;
  - res_count=1.
- Underrun: FIFO empties after word 10 and refills 20 cycles later -> block idles with word_cnt=11, resumes, out_last on the correct final beat.
- Reset mid-result after 5 words, then a clean 64-word result -> only the clean result completes, with res_count=1.
